jpeg_block_scheduler: RTL and testbench
=======================================

# jpeg_block_scheduler

- Shares one DCT/coder input port between the three component streams (Y, Cb, Cr) produced by the ping-pong line buffer.
- Arbitrates at 8x8-block granularity: once a channel is granted, all BLOCK_BEATS samples of its block pass before the grant can change.
- Tags every output beat with its component id and block boundaries.
- Sits between the ping-pong buffer outputs and the shared JPEG coding pipeline.

## Interface
Parameters:
- DATA_W, 8, sample width per beat
- N_CH, 3, number of requester channels (0=Y, 1=Cb, 2=Cr)
- BLOCK_BEATS, 64, beats per block

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  N_CH  per-channel beat valid
- in_ready  out  N_CH  per-channel beat accept
- in_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- out_valid  out  1  beat valid to coder
- out_ready  in  1  coder accepts beat
- out_data  out  DATA_W  muxed sample
- out_comp  out  2  component id of current beat
- out_sop  out  1  first beat of block
- out_eop  out  1  last beat of block
- mcu_done  out  1  one-cycle pulse, MCU complete
- busy  out  1  high while in BURST

## Operation
- FSM states:
  - ARB: choose a channel, register the grant, go to BURST next cycle.
  - BURST: forward the granted channel until the last beat is accepted, then return to ARB.
- Beat handshake: a beat transfers when out_valid && out_ready.
- Muxing (combinational from the registered grant):
  - out_valid = in_valid[g]; in_ready[g] = out_ready; all other in_ready = 0.
  - out_data = in_data[g]; out_comp = g.
- beat_cnt (6 bits for the default): clears on grant, increments per transfer.
  - out_sop = (beat_cnt == 0); out_eop = (beat_cnt == BLOCK_BEATS-1). Both qualified by out_valid.
- Requester dropping in_valid mid-block inserts a bubble. The grant is held; no re-arbitration mid-block.
- Round-robin mode (default):
  - Work-conserving. Search starts at (last_grant+1) mod N_CH; the first channel with in_valid high wins.
  - No requester valid: stay in ARB.
  - mcu_done pulses on the eop transfer of a channel-2 block.
- In ARB, outputs forced: out_valid=0, all in_ready=0, out_sop=out_eop=0.
- Reset:
  - Registered state: state=ARB, last_grant=N_CH-1 (so channel 0 has first priority), beat_cnt=0, seq_idx=0.
  - Outputs held low during reset: out_valid, in_ready, out_sop, out_eop, mcu_done, busy.
  - Reset mid-block abandons the block: no eop, no mcu_done. The coder must be reset in the same cycle.

## Timing
- Zero-cycle data path: a granted beat appears at the output combinationally.
- Arbitration costs exactly one bubble cycle between blocks (the ARB cycle).
- Steady-state throughput: BLOCK_BEATS beats per BLOCK_BEATS+1 cycles.
- out_ready low stalls: beat_cnt and the grant are held, out_data follows in_data[g]. Requesters must hold data while not accepted.
- mcu_done is registered: it is high in the cycle after the qualifying eop transfer.
- busy = (state == BURST).

## Configuration
- Macro: JPEG_SCHED_420_EN.
- Defined: fixed 4:2:0 MCU order. seq_idx 0..5 maps to channels 0,0,0,0,1,2.
  - ARB waits for in_valid of the scheduled channel only; other channels are not served out of order.
  - seq_idx advances on each eop transfer and wraps 5 -> 0.
  - mcu_done pulses when the eop of seq_idx 5 transfers.
- Undefined: round-robin as described in Operation; seq_idx logic is absent.

## Test plan
- Single channel: ch1 only, 64 beats data=0..63, out_ready=1.
  - Expect out_comp=1 on all beats; sop on data 0, eop on data 63.
  - Expect one ARB cycle, then busy for 64 cycles.
- Round robin: all three channels continuously valid.
  - Grants run 0,1,2,0,1,2 with one idle cycle between blocks.
  - mcu_done fires after each ch2 eop.
- Backpressure: out_ready toggles 1/0 every cycle mid-block, plus a ch0 valid gap of 5 cycles.
  - 64 beats delivered in order, none lost or duplicated; grant never changes mid-block.
- Reset at beat 30 of a ch2 block: assert rst for 1 cycle.
  - Next cycle: out_valid=0, busy=0, no eop, no mcu_done.
  - Next grant goes to ch0.
- JPEG_SCHED_420_EN: ch1 and ch2 valid first, ch0 valid 100 cycles later.
  - Nothing is granted until ch0 is valid.
  - Order is Y,Y,Y,Y,Cb,Cr; mcu_done fires once after the Cr eop; seq_idx wraps to 0.

Source files
------------

// File: rtl/jpeg_block_scheduler.sv
// Block-granular arbiter sharing one coder input port among the Y/Cb/Cr streams.
// Define JPEG_SCHED_420_EN for a fixed 4:2:0 MCU order (Y,Y,Y,Y,Cb,Cr) instead of round-robin.
module jpeg_block_scheduler #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned N_CH        = 3,
    parameter int unsigned BLOCK_BEATS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_comp,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     mcu_done,
    output logic                     busy
);

    localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [GW-1:0] LastCh   = GW'(N_CH - 1);
    localparam logic [CW-1:0] LastBeat = CW'(BLOCK_BEATS - 1);

    typedef enum logic {StArb, StBurst} state_e;

    state_e        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant_q;
    logic [CW-1:0] beat_cnt_q;
    logic          mcu_done_q;

    logic [GW-1:0] pick;
    logic          pick_vld;
    logic          mcu_last;
    logic          active;
    logic          xfer;
    logic          last_beat;

`ifdef JPEG_SCHED_420_EN
    logic [2:0] seq_idx_q;

    // Only the scheduled component may be granted; others wait their turn.
    always_comb begin
        pick = '0;
        case (seq_idx_q)
            3'd4:    pick = GW'(1);
            3'd5:    pick = GW'(2);
            default: pick = '0;
        endcase
        pick_vld = in_valid[pick];
    end

    assign mcu_last = (seq_idx_q == 3'd5);
`else
    logic [GW-1:0] cand;

    // Work-conserving search starting just after the last grant.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = last_grant_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = (cand == LastCh) ? '0 : cand + GW'(1);
            if (!pick_vld && in_valid[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    assign mcu_last = (grant_q == GW'(2));
`endif

    assign active    = (state_q == StBurst) && !rst;
    assign out_valid = active && in_valid[grant_q];
    assign out_data  = in_data[grant_q*DATA_W +: DATA_W];
    assign out_comp  = 2'(grant_q);
    assign xfer      = out_valid && out_ready;
    assign last_beat = (beat_cnt_q == LastBeat);
    assign out_sop   = out_valid && (beat_cnt_q == '0);
    assign out_eop   = out_valid && last_beat;
    assign busy      = active;
    assign mcu_done  = mcu_done_q && !rst;

    always_comb begin
        in_ready = '0;
        if (active) begin
            in_ready[grant_q] = out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StArb;
            grant_q      <= '0;
            last_grant_q <= LastCh;
            beat_cnt_q   <= '0;
            mcu_done_q   <= 1'b0;
`ifdef JPEG_SCHED_420_EN
            seq_idx_q    <= '0;
`endif
        end else begin
            mcu_done_q <= 1'b0;
            unique case (state_q)
                StArb: begin
                    if (pick_vld) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        beat_cnt_q   <= '0;
                        state_q      <= StBurst;
                    end
                end
                StBurst: begin
                    if (xfer) begin
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            state_q    <= StArb;
                            mcu_done_q <= mcu_last;
`ifdef JPEG_SCHED_420_EN
                            seq_idx_q  <= (seq_idx_q == 3'd5) ? 3'd0 : seq_idx_q + 3'd1;
`endif
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Directed bench for jpeg_block_scheduler: single channel, round-robin, backpressure,
// mid-block reset, and (with JPEG_SCHED_420_EN) the fixed 4:2:0 order.
module tb_jpeg_block_scheduler;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_CH   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [N_CH*DATA_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             out_comp;
    logic                   out_sop;
    logic                   out_eop;
    logic                   mcu_done;
    logic                   busy;

    // Per-channel sample counters: each requester presents its next sample until accepted.
    logic [7:0] d0, d1, d2;
    assign in_data = {d2, d1, d0};

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int rx;
    int bad;
    int n;

    always #5 clk = ~clk;

    jpeg_block_scheduler #(
        .DATA_W     (DATA_W),
        .N_CH       (N_CH),
        .BLOCK_BEATS(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_comp (out_comp),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .mcu_done (mcu_done),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: note any transfer, cross the next posedge, advance the source.
    task automatic adv();
        logic       fire;
        logic [1:0] c;
        fire = out_valid && out_ready;
        c    = out_comp;
        @(posedge clk);
        #1;
        if (fire) begin
            case (c)
                2'd0:    d0++;
                2'd1:    d1++;
                default: d2++;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = '0; out_ready = 1'b1; d0 = 0; d1 = 0; d2 = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_outs", {out_valid, in_ready, out_sop, out_eop, mcu_done, busy}, 0);
        adv();
        rst = 1'b0;

        // Single channel: ch1 only, data 0..63
        in_valid = 3'b010;
        @(negedge clk);
        check("t1_arb", {busy, out_valid, in_ready}, 0);
        adv();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("t1_beat", {busy, out_valid, in_ready, out_comp, out_sop, out_eop, out_data},
                  {1'b1, 1'b1, 3'b010, 2'd1, i == 0, i == 63, 8'(i)});
            adv();
        end
        in_valid = '0;
        @(negedge clk);
        check("t1_after", {busy, out_valid, mcu_done}, 0);
        adv();

        // Round robin: all three valid, expect 0,1,2,0,1,2 with one ARB cycle each
        rst = 1'b1; adv(); rst = 1'b0;
        d0 = 0; d1 = 0; d2 = 0; in_valid = 3'b111; bad = 0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            check("t2_arb", {busy, out_valid, mcu_done}, {2'b00, (b > 0) && ((b - 1) % 3 == 2)});
            adv();
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (out_comp != 2'(b % 3) || !out_valid || !busy || mcu_done
                    || out_eop != (i == 63)) bad++;
                if (i == 0)
                    check("t2_sop", {out_sop, out_comp, out_data}, {1'b1, 2'(b % 3), 8'((b / 3) * 64)});
                adv();
            end
        end
        in_valid = '0;
        @(negedge clk);
        check("t2_mcu_last", {busy, mcu_done}, 2'b01);
        check("t2_beats", bad, 0);
        adv();
        @(negedge clk);
        check("t2_mcu_pulse", mcu_done, 0);
        adv();

        // Backpressure: out_ready toggles, ch0 drops valid for 5 cycles
        rst = 1'b1; adv(); rst = 1'b0;
        d0 = 0; in_valid = 3'b001; out_ready = 1'b1;
        @(negedge clk);
        check("t3_arb", busy, 0);
        adv();
        rx = 0; bad = 0; n = 0;
        while (rx < 64 && n < 400) begin
            out_ready   = (n % 2 == 0);
            in_valid[0] = !(n >= 20 && n < 25);
            @(negedge clk);
            if (!busy || out_comp != 2'd0 || in_ready[2:1] != 2'b00) bad++;
            if (n >= 20 && n < 25 && out_valid) bad++;
            if (out_valid && out_ready) begin
                if (out_data != 8'(rx) || out_sop != (rx == 0) || out_eop != (rx == 63)) bad++;
                rx++;
            end else if (out_eop && rx != 63) begin
                bad++;
            end
            adv();
            n++;
        end
        in_valid = '0; out_ready = 1'b1;
        check("t3_count", rx, 64);
        check("t3_bad", bad, 0);
        @(negedge clk);
        check("t3_done", {busy, mcu_done}, 0);
        adv();

        // Reset at beat 30 of a ch2 block
        rst = 1'b1; adv(); rst = 1'b0;
        d2 = 0; in_valid = 3'b100;
        @(negedge clk);
        adv();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            adv();
        end
        @(negedge clk);
        check("t4_beat30", {out_valid, out_comp, out_data}, {1'b1, 2'd2, 8'd30});
        rst = 1'b1;
        #1;
        check("t4_rst_hold", {out_valid, in_ready, busy, out_sop, out_eop}, 0);
        adv();
        rst = 1'b0; in_valid = 3'b111; d0 = 0;
        @(negedge clk);
        check("t4_after", {out_valid, busy, out_eop, mcu_done}, 0);
        adv();
        @(negedge clk);
        check("t4_grant", {busy, out_comp, out_sop, out_data}, {1'b1, 2'd0, 1'b1, 8'd0});
        adv();
        @(negedge clk);
        check("t4_mcu", mcu_done, 0);
        in_valid = '0;
        rst = 1'b1; adv(); rst = 1'b0;

`ifdef JPEG_SCHED_420_EN
        // 4:2:0 order: chroma valid first, luma 100 cycles later
        d0 = 0; d1 = 0; d2 = 0; in_valid = 3'b110; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy || out_valid || in_ready != 3'b000) bad++;
            adv();
        end
        check("t5_wait", bad, 0);
        in_valid = 3'b111;
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            check("t5_arb", {busy, mcu_done}, {1'b0, b == 6});
            adv();
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (i == 0)
                    check("t5_comp", {out_sop, out_comp},
                          {1'b1, (b == 4) ? 2'd1 : (b == 5) ? 2'd2 : 2'd0});
                adv();
            end
        end
        in_valid = '0;
        rst = 1'b1; adv(); rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
